// File: rtl/ivs_cfg_seq_if.sv
// AHB-lite bus bundle between the IVS configuration sequencer (master) and the IVS
// register slave.
interface ivs_cfg_seq_if;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [1:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, htrans, hwrite, haddr, hwdata, hsize, hburst, hprot,
    input  hready, hresp, hrdata
  );

  modport slave (
    input  hsel, htrans, hwrite, haddr, hwdata, hsize, hburst, hprot,
    output hready, hresp, hrdata
  );
endinterface

// File: rtl/ivs_cfg_seq.sv
// AHB-lite master that writes an 8-entry cfg_par table to the IVS slave, optionally
// reads it back for comparison, then writes the global control word.
module ivs_cfg_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned PAR_NUM   = 8
) (
  input  logic          hclk,
  input  logic          hrst,
  input  logic          start,
  input  logic          verify_en,
  input  logic [31:0]   glb_val,
  input  logic          tbl_we,
  input  logic [2:0]    tbl_addr,
  input  logic [31:0]   tbl_wdata,
  ivs_cfg_seq_if.master ahb,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [3:0]    err_idx
);

  localparam logic [2:0]  LastIdx = 3'(PAR_NUM - 1);
  localparam logic [31:0] ParBase = BASE_ADDR + 32'h0000_0100;
  localparam logic [1:0]  TransIdle   = 2'b00;
  localparam logic [1:0]  TransNonseq = 2'b10;

  typedef enum logic [2:0] {
    StIdle, StWaddr, StWdata, StRaddr, StRdata, StGaddr, StGdata, StFin
  } state_e;

  state_e      state_q;
  logic [2:0]  idx_q;
  logic        verify_q;
  logic [31:0] glb_q;
  logic [31:0] tbl_q [8];

  logic [2:0]  idx_nxt;
  logic        idx_last;
  logic        resp_err;

  assign idx_nxt  = idx_q + 3'd1;
  assign idx_last = (idx_q == LastIdx);
  assign resp_err = |ahb.hresp;

  assign ahb.hsize  = 2'b10;
  assign ahb.hburst = 3'b000;
  assign ahb.hprot  = 4'b0011;

  function automatic logic [31:0] par_addr(input logic [2:0] i);
    return ParBase + {27'd0, i, 2'b00};
  endfunction

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      verify_q   <= 1'b0;
      glb_q      <= 32'd0;
      for (int i = 0; i < 8; i++) tbl_q[i] <= 32'd0;
      ahb.hsel   <= 1'b0;
      ahb.htrans <= TransIdle;
      ahb.hwrite <= 1'b0;
      ahb.haddr  <= 32'd0;
      ahb.hwdata <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      err_idx    <= 4'd0;
    end else begin
      done <= 1'b0;
      // busy is low only in IDLE and FIN, so the table never changes mid-sequence
      if (tbl_we && !busy) tbl_q[tbl_addr] <= tbl_wdata;

      case (state_q)
        StIdle: begin
          if (start) begin
            verify_q   <= verify_en;
            glb_q      <= glb_val;
            err        <= 1'b0;
            err_idx    <= 4'd0;
            idx_q      <= 3'd0;
            busy       <= 1'b1;
            ahb.hsel   <= 1'b1;
            ahb.htrans <= TransNonseq;
            ahb.hwrite <= 1'b1;
            ahb.haddr  <= par_addr(3'd0);
            state_q    <= StWaddr;
          end
        end

        StWaddr: begin
          if (ahb.hready) begin
            ahb.hsel   <= 1'b0;
            ahb.htrans <= TransIdle;
            ahb.hwdata <= tbl_q[idx_q];
            state_q    <= StWdata;
          end
        end

        StWdata: begin
          if (ahb.hready) begin
            if (resp_err) begin
              err     <= 1'b1;
              err_idx <= {1'b0, idx_q};
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StFin;
            end else if (!idx_last) begin
              idx_q      <= idx_nxt;
              ahb.hsel   <= 1'b1;
              ahb.htrans <= TransNonseq;
              ahb.hwrite <= 1'b1;
              ahb.haddr  <= par_addr(idx_nxt);
              state_q    <= StWaddr;
            end else if (verify_q) begin
              idx_q      <= 3'd0;
              ahb.hsel   <= 1'b1;
              ahb.htrans <= TransNonseq;
              ahb.hwrite <= 1'b0;
              ahb.haddr  <= par_addr(3'd0);
              state_q    <= StRaddr;
            end else begin
              idx_q      <= 3'd0;
              ahb.hsel   <= 1'b1;
              ahb.htrans <= TransNonseq;
              ahb.hwrite <= 1'b1;
              ahb.haddr  <= BASE_ADDR;
              state_q    <= StGaddr;
            end
          end
        end

        StRaddr: begin
          if (ahb.hready) begin
            ahb.hsel   <= 1'b0;
            ahb.htrans <= TransIdle;
            state_q    <= StRdata;
          end
        end

        StRdata: begin
          if (ahb.hready) begin
            if (resp_err || (ahb.hrdata != tbl_q[idx_q])) begin
              err     <= 1'b1;
              err_idx <= {1'b0, idx_q};
              busy    <= 1'b0;
              done    <= 1'b1;
              state_q <= StFin;
            end else if (!idx_last) begin
              idx_q      <= idx_nxt;
              ahb.hsel   <= 1'b1;
              ahb.htrans <= TransNonseq;
              ahb.hwrite <= 1'b0;
              ahb.haddr  <= par_addr(idx_nxt);
              state_q    <= StRaddr;
            end else begin
              idx_q      <= 3'd0;
              ahb.hsel   <= 1'b1;
              ahb.htrans <= TransNonseq;
              ahb.hwrite <= 1'b1;
              ahb.haddr  <= BASE_ADDR;
              state_q    <= StGaddr;
            end
          end
        end

        StGaddr: begin
          if (ahb.hready) begin
            ahb.hsel   <= 1'b0;
            ahb.htrans <= TransIdle;
            ahb.hwdata <= glb_q;
            state_q    <= StGdata;
          end
        end

        StGdata: begin
          if (ahb.hready) begin
            if (resp_err) begin
              err     <= 1'b1;
              err_idx <= 4'd8;
            end
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StFin;
          end
        end

        StFin: state_q <= StIdle;

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ivs_cfg_seq.sv
// Directed bench for ivs_cfg_seq: a procedural AHB slave model records transfers and
// each scenario task checks its own expectations.
module tb_ivs_cfg_seq;

  logic        hclk;
  logic        hrst;
  logic        start;
  logic        verify_en;
  logic [31:0] glb_val;
  logic        tbl_we;
  logic [2:0]  tbl_addr;
  logic [31:0] tbl_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [3:0]  err_idx;

  ivs_cfg_seq_if ahb ();

  ivs_cfg_seq #(
    .BASE_ADDR(32'h0000_0000),
    .PAR_NUM  (8)
  ) dut (
    .hclk     (hclk),
    .hrst     (hrst),
    .start    (start),
    .verify_en(verify_en),
    .glb_val  (glb_val),
    .tbl_we   (tbl_we),
    .tbl_addr (tbl_addr),
    .tbl_wdata(tbl_wdata),
    .ahb      (ahb),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_idx  (err_idx)
  );

  always #5 hclk = ~hclk;

  int checks;
  int errors;

  // Slave model knobs and transfer log
  int          rd_wait;
  logic        bad_en;
  logic [31:0] bad_addr;
  logic        glb_err;
  logic [31:0] stall_addr;
  int          stall_left;
  int          stall_seen;
  int          stall_bad;
  logic        busy_poke;
  logic        rst_en;
  logic [31:0] rst_addr;
  logic        rst_hit;
  logic        rst_busy;
  logic [1:0]  rst_htrans;
  logic        rst_hsel;
  int          done_cyc;
  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [31:0] rd_addr [$];
  logic [31:0] mem [8];

  task automatic load_tbl();
    for (int i = 0; i < 8; i++) begin
      @(negedge hclk);
      tbl_we    = 1'b1;
      tbl_addr  = 3'(i);
      tbl_wdata = 32'hA0 + 32'(i);
    end
    @(negedge hclk);
    tbl_we = 1'b0;
  endtask

  // Pulses start, then plays the slave cycle by cycle until done (or reset injection).
  task automatic run_seq(input logic ven, input logic [31:0] gv);
    int          cyc;
    logic        dp_valid;
    logic        dp_write;
    logic [31:0] dp_addr;
    int          dp_wait;
    wr_addr.delete();
    wr_data.delete();
    rd_addr.delete();
    dp_valid   = 1'b0;
    dp_write   = 1'b0;
    dp_addr    = 32'd0;
    dp_wait    = 0;
    stall_seen = 0;
    stall_bad  = 0;
    rst_hit    = 1'b0;
    done_cyc   = -1;
    @(negedge hclk);
    verify_en  = ven;
    glb_val    = gv;
    start      = 1'b1;
    ahb.hready = 1'b1;
    ahb.hresp  = 2'b00;
    cyc = 0;
    while (1) begin
      @(negedge hclk);
      start  = 1'b0;
      tbl_we = 1'b0;
      cyc++;
      if (busy_poke && cyc == 5) begin
        start     = 1'b1;
        tbl_we    = 1'b1;
        tbl_addr  = 3'd0;
        tbl_wdata = 32'hFFFF_FFFF;
      end
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (cyc > 400) begin
        checks++;
        errors++;
        $display("FAIL run_timeout cycles %0d required done within 400", cyc);
        break;
      end
      ahb.hready = 1'b1;
      ahb.hresp  = 2'b00;
      if (!dp_valid && stall_left > 0 &&
          (stall_seen > 0 || (ahb.hsel && ahb.haddr == stall_addr))) begin
        if ({ahb.hsel, ahb.htrans, ahb.hwrite, ahb.haddr} !== {1'b1, 2'b10, 1'b1, stall_addr})
          stall_bad++;
        ahb.hready = 1'b0;
        stall_left--;
        stall_seen++;
      end else if (dp_valid) begin
        if (dp_wait > 0) begin
          ahb.hready = 1'b0;
          dp_wait--;
          if (rst_en && !dp_write && dp_addr == rst_addr) begin
            hrst = 1'b1;
            #1;
            rst_busy   = busy;
            rst_htrans = ahb.htrans;
            rst_hsel   = ahb.hsel;
            rst_hit    = 1'b1;
            break;
          end
        end else begin
          if (dp_write) begin
            wr_addr.push_back(dp_addr);
            wr_data.push_back(ahb.hwdata);
            if (dp_addr[8]) mem[dp_addr[4:2]] = ahb.hwdata;
            if (glb_err && dp_addr == 32'h0) ahb.hresp = 2'b01;
          end else begin
            rd_addr.push_back(dp_addr);
            ahb.hrdata = (bad_en && dp_addr == bad_addr) ? 32'hDEAD : mem[dp_addr[4:2]];
          end
          dp_valid = 1'b0;
        end
      end else if (ahb.hsel && ahb.htrans == 2'b10) begin
        dp_valid = 1'b1;
        dp_addr  = ahb.haddr;
        dp_write = ahb.hwrite;
        dp_wait  = ahb.hwrite ? 0 : rd_wait;
      end
    end
    ahb.hready = 1'b1;
    ahb.hresp  = 2'b00;
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({ahb.hsel, ahb.htrans, ahb.hwrite, ahb.hsize, ahb.hburst, ahb.hprot} !==
        {1'b0, 2'b00, 1'b0, 2'b10, 3'b000, 4'b0011}) begin
      errors++;
      $display("FAIL reset_ctrl got %b required %b",
               {ahb.hsel, ahb.htrans, ahb.hwrite, ahb.hsize, ahb.hburst, ahb.hprot},
               {1'b0, 2'b00, 1'b0, 2'b10, 3'b000, 4'b0011});
    end
    checks++;
    if ({ahb.haddr, ahb.hwdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_addr_data got %h %h required 0 0", ahb.haddr, ahb.hwdata);
    end
    checks++;
    if ({busy, done, err, err_idx} !== 7'd0) begin
      errors++;
      $display("FAIL reset_status got %b required 0000000", {busy, done, err, err_idx});
    end
    @(negedge hclk);
    @(negedge hclk);
    hrst = 1'b0;
  endtask

  task automatic test_basic();
    load_tbl();
    run_seq(1'b0, 32'h1);
    checks++;
    if (done_cyc != 19) begin
      errors++;
      $display("FAIL basic_latency got %0d required 19", done_cyc);
    end
    checks++;
    if (wr_addr.size() != 9 || rd_addr.size() != 0) begin
      errors++;
      $display("FAIL basic_counts got wr %0d rd %0d required 9 0", wr_addr.size(), rd_addr.size());
    end
    for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
      checks++;
      if (wr_addr[i] !== 32'h100 + 32'(4 * i) || wr_data[i] !== 32'hA0 + 32'(i)) begin
        errors++;
        $display("FAIL basic_wr[%0d] got %h=%h required %h=%h", i, wr_addr[i], wr_data[i],
                 32'h100 + 32'(4 * i), 32'hA0 + 32'(i));
      end
    end
    if (wr_addr.size() == 9) begin
      checks++;
      if (wr_addr[8] !== 32'h0 || wr_data[8] !== 32'h1) begin
        errors++;
        $display("FAIL basic_glb got %h=%h required 00000000=00000001", wr_addr[8], wr_data[8]);
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL basic_err got %b required 0", err);
    end
    @(negedge hclk);
    checks++;
    if ({done, busy} !== 2'b00) begin
      errors++;
      $display("FAIL basic_done_pulse got done %b busy %b required 0 0", done, busy);
    end
  endtask

  task automatic test_verify();
    rd_wait = 1;
    run_seq(1'b1, 32'h1);
    checks++;
    if (done_cyc != 43) begin
      errors++;
      $display("FAIL verify_latency got %0d required 43", done_cyc);
    end
    checks++;
    if (rd_addr.size() != 8 || wr_addr.size() != 9) begin
      errors++;
      $display("FAIL verify_counts got rd %0d wr %0d required 8 9", rd_addr.size(), wr_addr.size());
    end
    for (int i = 0; i < 8 && i < rd_addr.size(); i++) begin
      checks++;
      if (rd_addr[i] !== 32'h100 + 32'(4 * i)) begin
        errors++;
        $display("FAIL verify_rd[%0d] got %h required %h", i, rd_addr[i], 32'h100 + 32'(4 * i));
      end
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL verify_err got %b required 0", err);
    end
  endtask

  task automatic test_mismatch();
    rd_wait  = 1;
    bad_en   = 1'b1;
    bad_addr = 32'h10C;
    run_seq(1'b1, 32'h1);
    bad_en = 1'b0;
    checks++;
    if ({err, err_idx} !== 5'b1_0011) begin
      errors++;
      $display("FAIL mismatch_err got %b/%0d required 1/3", err, err_idx);
    end
    checks++;
    if (wr_addr.size() != 8 || rd_addr.size() != 4) begin
      errors++;
      $display("FAIL mismatch_counts got wr %0d rd %0d required 8 4", wr_addr.size(), rd_addr.size());
    end
    checks++;
    if (done_cyc != 29) begin
      errors++;
      $display("FAIL mismatch_latency got %0d required 29", done_cyc);
    end
  endtask

  task automatic test_glb_err();
    rd_wait = 0;
    glb_err = 1'b1;
    run_seq(1'b0, 32'h1234);
    glb_err = 1'b0;
    checks++;
    if ({err, err_idx} !== 5'b1_1000) begin
      errors++;
      $display("FAIL glb_err got %b/%0d required 1/8", err, err_idx);
    end
    checks++;
    if (done_cyc != 19 || wr_addr.size() != 9) begin
      errors++;
      $display("FAIL glb_err_seq got done %0d wr %0d required 19 9", done_cyc, wr_addr.size());
    end
  endtask

  task automatic test_stall();
    stall_addr = 32'h108;
    stall_left = 5;
    run_seq(1'b0, 32'h1);
    stall_left = 0;
    checks++;
    if (stall_seen != 5 || stall_bad != 0) begin
      errors++;
      $display("FAIL stall_hold got seen %0d unstable %0d required 5 0", stall_seen, stall_bad);
    end
    checks++;
    if (done_cyc != 24) begin
      errors++;
      $display("FAIL stall_latency got %0d required 24", done_cyc);
    end
    checks++;
    if (wr_addr.size() != 9 || wr_addr[2] !== 32'h108 || wr_data[2] !== 32'hA2 ||
        wr_data[3] !== 32'hA3) begin
      errors++;
      $display("FAIL stall_resume got wr %0d data2 %h data3 %h required 9 a2 a3",
               wr_addr.size(), wr_data[2], wr_data[3]);
    end
  endtask

  task automatic test_back_to_back();
    busy_poke = 1'b1;
    run_seq(1'b0, 32'h55);
    busy_poke = 1'b0;
    checks++;
    if (done_cyc != 19 || wr_addr.size() != 9 || err !== 1'b0) begin
      errors++;
      $display("FAIL b2b_busy_start got done %0d wr %0d err %b required 19 9 0",
               done_cyc, wr_addr.size(), err);
    end
    // start in the FIN cycle must be ignored
    start = 1'b1;
    @(negedge hclk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_fin_start got busy %b required 0", busy);
    end
    @(negedge hclk);
    checks++;
    if (busy !== 1'b0 || ahb.hsel !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle got busy %b hsel %b required 0 0", busy, ahb.hsel);
    end
    run_seq(1'b0, 32'h55);
    checks++;
    if (wr_data.size() != 9 || wr_data[0] !== 32'hA0 || wr_data[8] !== 32'h55) begin
      errors++;
      $display("FAIL b2b_tbl_locked got wr %0d data0 %h glb %h required 9 a0 55",
               wr_data.size(), wr_data[0], wr_data[8]);
    end
  endtask

  task automatic test_reset_mid();
    rd_wait  = 1;
    rst_en   = 1'b1;
    rst_addr = 32'h110;
    run_seq(1'b1, 32'h1);
    rst_en = 1'b0;
    checks++;
    if ({rst_hit, rst_busy, rst_hsel, rst_htrans} !== 5'b1_0_0_00) begin
      errors++;
      $display("FAIL rst_mid got hit %b busy %b hsel %b htrans %b required 1 0 0 00",
               rst_hit, rst_busy, rst_hsel, rst_htrans);
    end
    @(negedge hclk);
    hrst    = 1'b0;
    rd_wait = 0;
    run_seq(1'b0, 32'h1);
    checks++;
    if (done_cyc != 19 || wr_addr.size() != 9 || wr_addr[0] !== 32'h100) begin
      errors++;
      $display("FAIL rst_rerun got done %0d wr %0d addr0 %h required 19 9 00000100",
               done_cyc, wr_addr.size(), wr_addr[0]);
    end
    for (int i = 0; i < 8 && i < wr_data.size(); i++) begin
      checks++;
      if (wr_data[i] !== 32'd0) begin
        errors++;
        $display("FAIL rst_tbl_clear[%0d] got %h required 00000000", i, wr_data[i]);
      end
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    hclk       = 1'b0;
    hrst       = 1'b1;
    start      = 1'b0;
    verify_en  = 1'b0;
    glb_val    = 32'd0;
    tbl_we     = 1'b0;
    tbl_addr   = 3'd0;
    tbl_wdata  = 32'd0;
    ahb.hready = 1'b1;
    ahb.hresp  = 2'b00;
    ahb.hrdata = 32'd0;
    rd_wait    = 0;
    bad_en     = 1'b0;
    bad_addr   = 32'd0;
    glb_err    = 1'b0;
    stall_addr = 32'd0;
    stall_left = 0;
    busy_poke  = 1'b0;
    rst_en     = 1'b0;
    rst_addr   = 32'd0;
    rst_busy   = 1'b0;
    rst_htrans = 2'b00;
    rst_hsel   = 1'b0;
    for (int i = 0; i < 8; i++) mem[i] = 32'd0;

    test_reset();
    test_basic();
    test_verify();
    test_mismatch();
    test_glb_err();
    test_stall();
    test_back_to_back();
    test_reset_mid();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
